// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
//
// Raster timing source for the pixel colour stage. Free-running horizontal and
// vertical counters produce the current pixel position, the visible-area flag
// and both sync pulses. A per-frame tick and a wrapping frame counter are also
// provided for animation. All outputs are registered and describe the same
// pixel in every cycle.
//
// Ports
//   clk          in   1   pixel-domain clock
//   rst_n        in   1   synchronous active-low reset (overrides ce)
//   ce           in   1   pixel clock enable; counters advance only when 1
//   hpos         out  10  current column, 0..H_TOTAL-1
//   vpos         out  10  current line, 0..V_TOTAL-1
//   visible      out  1   1 when hpos < H_ACTIVE and vpos < V_ACTIVE
//   hsync        out  1   horizontal sync, SYNC_POL when asserted
//   vsync        out  1   vertical sync, SYNC_POL when asserted
//   frame_tick   out  1   one-clk pulse in the cycle (hpos,vpos) becomes (0,0)
//   frame_count  out  10  frames completed since reset, wraps modulo 1024
// -----------------------------------------------------------------------------
module vga_timing_gen #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter bit          SYNC_POL = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ce,
    output logic [9:0] hpos,
    output logic [9:0] vpos,
    output logic       visible,
    output logic       hsync,
    output logic       vsync,
    output logic       frame_tick,
    output logic [9:0] frame_count
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Geometry constants pre-sized to the counter width so every compare
    // below is a plain 10-bit operation.
    localparam logic [9:0] H_LAST       = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST       = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT        = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT        = 10'(V_ACTIVE);
    localparam logic [9:0] H_SYNC_FIRST = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] H_SYNC_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] V_SYNC_FIRST = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] V_SYNC_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

    // Inclusive window test on a counter value.
    function automatic logic in_window(
        input logic [9:0] pos,
        input logic [9:0] first,
        input logic [9:0] last
    );
        return (pos >= first) && (pos <= last);
    endfunction

    // Map "sync asserted" to the physical pin level.
    function automatic logic sync_level(input logic asserted);
        return asserted ? SYNC_POL : ~SYNC_POL;
    endfunction

    logic [9:0] hcnt_q, hcnt_d;
    logic [9:0] vcnt_q, vcnt_d;
    logic [9:0] fcnt_q, fcnt_d;
    logic       visible_q, visible_d;
    logic       hsync_q, hsync_d;
    logic       vsync_q, vsync_d;
    logic       tick_q, tick_d;

    logic       h_last;
    logic       v_last;
    logic       line_wrap;
    logic       frame_wrap;

    assign h_last     = (hcnt_q == H_LAST);
    assign v_last     = (vcnt_q == V_LAST);
    assign line_wrap  = ce && h_last;
    assign frame_wrap = line_wrap && v_last;

    // Counter next-state. With ce=0 every _d equals its _q, so the decoded
    // flags below also hold without a separate enable path.
    always_comb begin
        hcnt_d = hcnt_q;
        vcnt_d = vcnt_q;
        fcnt_d = fcnt_q;

        if (ce) begin
            hcnt_d = h_last ? 10'd0 : hcnt_q + 10'd1;
        end

        if (line_wrap) begin
            vcnt_d = v_last ? 10'd0 : vcnt_q + 10'd1;
        end

        // Natural 10-bit wrap gives 1023 -> 0 without saturation.
        if (frame_wrap) begin
            fcnt_d = fcnt_q + 10'd1;
        end
    end

    // Flags are decoded from the next counter values and registered together
    // with the counters, so hpos/vpos and the flags are never skewed and the
    // outputs come straight from flops (no decode glitches).
    always_comb begin
        visible_d = (hcnt_d < H_ACT) && (vcnt_d < V_ACT);
        hsync_d   = sync_level(in_window(hcnt_d, H_SYNC_FIRST, H_SYNC_LAST));
        // vcnt only changes on the line wrap, so vsync spans whole lines.
        vsync_d   = sync_level(in_window(vcnt_d, V_SYNC_FIRST, V_SYNC_LAST));
        tick_d    = frame_wrap;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hcnt_q    <= 10'd0;
            vcnt_q    <= 10'd0;
            fcnt_q    <= 10'd0;
            visible_q <= 1'b1;
            hsync_q   <= ~SYNC_POL;
            vsync_q   <= ~SYNC_POL;
            tick_q    <= 1'b0;
        end else begin
            hcnt_q    <= hcnt_d;
            vcnt_q    <= vcnt_d;
            fcnt_q    <= fcnt_d;
            visible_q <= visible_d;
            hsync_q   <= hsync_d;
            vsync_q   <= vsync_d;
            tick_q    <= tick_d;
        end
    end

    assign hpos        = hcnt_q;
    assign vpos        = vcnt_q;
    assign visible     = visible_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign frame_tick  = tick_q;
    assign frame_count = fcnt_q;

endmodule
